// File: rtl/neuron_backprop_engine.sv
// Single-neuron backpropagation engine.
// Captures an error/learning-rate/input snapshot on start, then walks the
// lanes one per cycle: it emits the error propagated upstream on each enabled
// lane and applies the Q16.16 gradient step to that lane's weight.
module neuron_backprop_engine #(
    parameter int          N_IN   = 32,
    parameter logic [31:0] W_INIT = 32'h00010000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [31:0]       delta,
    input  logic signed [31:0]       rate,
    input  logic [N_IN-1:0]          enabled,
    input  logic [N_IN*32-1:0]       in_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     back_valid,
    output logic [4:0]               back_idx,
    output logic signed [31:0]       back_val,
    input  logic [4:0]               w_rd_idx,
    output logic signed [31:0]       w_rd_data
);

    typedef enum logic [1:0] {IDLE, STEP, LANE, DONE} state_t;

    localparam logic [4:0] LAST_LANE = 5'(N_IN - 1);

    // Clamp a wide signed value into the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
        if (x > 64'sh0000_0000_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (x < 64'shFFFF_FFFF_8000_0000)
            return 32'sh8000_0000;
        else
            return x[31:0];
    endfunction

    // Q16.16 multiply: full 64-bit signed product, arithmetic shift, saturate.
    function automatic logic signed [31:0] mulq(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return sat32(p >>> 16);
    endfunction

    state_t                state_q, state_d;
    logic [4:0]            lane_q;
    logic signed [31:0]    delta_q, rate_q, step_q;
    logic [N_IN-1:0]       en_q;
    logic [N_IN*32-1:0]    in_q;
    logic signed [31:0]    w_q [N_IN];
    logic                  done_q, back_valid_q;
    logic [4:0]            back_idx_q;
    logic signed [31:0]    back_val_q;

    logic signed [31:0]    cur_w, cur_in, back_d, w_d;
    logic                  cur_en;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STEP;
            STEP:    state_d = LANE;
            LANE:    if (lane_q == LAST_LANE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select the current lane's weight, input and enable; compute its results.
    always_comb begin
        cur_w  = '0;
        cur_in = '0;
        cur_en = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (lane_q == 5'(i)) begin
                cur_w  = w_q[i];
                cur_in = in_q[32*i +: 32];
                cur_en = en_q[i];
            end
        end
        // Upstream error uses the weight before this lane's update.
        back_d = mulq(delta_q, cur_w);
        w_d    = sat32(64'(cur_w) + 64'(mulq(step_q, cur_in)));
    end

    // Capture, step computation, per-lane weight update and strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q       <= '0;
            delta_q      <= '0;
            rate_q       <= '0;
            step_q       <= '0;
            en_q         <= '0;
            in_q         <= '0;
            done_q       <= 1'b0;
            back_valid_q <= 1'b0;
            back_idx_q   <= '0;
            back_val_q   <= '0;
            for (int i = 0; i < N_IN; i++)
                w_q[i] <= W_INIT;
        end else begin
            done_q       <= 1'b0;
            back_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        delta_q <= delta;
                        rate_q  <= rate;
                        en_q    <= enabled;
                        in_q    <= in_vec;
                        lane_q  <= '0;
                    end
                end
                STEP: begin
                    step_q <= mulq(rate_q, delta_q);
                end
                LANE: begin
                    if (cur_en) begin
                        back_valid_q <= 1'b1;
                        back_idx_q   <= lane_q;
                        back_val_q   <= back_d;
                    end
                    for (int i = 0; i < N_IN; i++) begin
                        if (cur_en && lane_q == 5'(i))
                            w_q[i] <= w_d;
                    end
                    lane_q <= (lane_q == LAST_LANE) ? 5'd0 : lane_q + 5'd1;
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Combinational weight read port; out-of-range lanes read zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_rd_idx == 5'(i))
                w_rd_data = w_q[i];
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign back_valid = back_valid_q;
    assign back_idx   = back_idx_q;
    assign back_val   = back_val_q;

endmodule

// File: tb/tb_neuron_backprop_engine.sv
// Scoreboard bench for neuron_backprop_engine.
module tb_neuron_backprop_engine;

    localparam int N = 32;
    localparam int W_INIT = 32'h00010000;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [31:0] delta, rate;
    logic [N-1:0]       enabled;
    logic [N*32-1:0]    in_vec;
    logic               busy, done, back_valid;
    logic [4:0]         back_idx;
    logic signed [31:0] back_val;
    logic [4:0]         w_rd_idx;
    logic signed [31:0] w_rd_data;

    neuron_backprop_engine #(.N_IN(N), .W_INIT(32'h00010000)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .delta      (delta),
        .rate       (rate),
        .enabled    (enabled),
        .in_vec     (in_vec),
        .busy       (busy),
        .done       (done),
        .back_valid (back_valid),
        .back_idx   (back_idx),
        .back_val   (back_val),
        .w_rd_idx   (w_rd_idx),
        .w_rd_data  (w_rd_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int sat(input longint x);
        if (x > longint'(32'sh7FFFFFFF)) return 32'sh7FFFFFFF;
        if (x < -longint'(64'h80000000)) return 32'sh80000000;
        return int'(x);
    endfunction

    function automatic int qmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat(p >>> 16);
    endfunction

    int mw [N];
    int exp_idx [$];
    int exp_val [$];
    int done_cnt = 0;
    bit ignore_back = 1'b0;

    // Scoreboard consumer: every back strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (back_valid && !ignore_back) begin
                if (exp_idx.size() == 0) begin
                    check_eq("back_extra", {27'b0, back_idx}, 32'hFFFFFFFF);
                end else begin
                    check_eq("back_idx", {27'b0, back_idx}, exp_idx.pop_front());
                    check_eq("back_val", back_val, exp_val.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < N; k++) mw[k] = W_INIT;
        exp_idx.delete();
        exp_val.delete();
    endtask

    task automatic scramble_inputs();
        delta   = $urandom;
        rate    = $urandom;
        enabled = $urandom;
        for (int k = 0; k < N; k++) in_vec[32*k +: 32] = $urandom;
    endtask

    task automatic check_weights(input string tag);
        for (int k = 0; k < N; k++) begin
            w_rd_idx = 5'(k);
            #1;
            check_eq($sformatf("%s_w%0d", tag, k), w_rd_data, mw[k]);
        end
    endtask

    // Drive one pass (optionally with a second start at edge restart_at),
    // push expectations, then check done timing, drain and final weights.
    task automatic run_pass(input int d, input int r, input logic [N-1:0] en,
                            input logic [N*32-1:0] iv, input int restart_at, input string tag);
        int step;
        int cyc;
        int base_done;
        bit seen;
        step = qmul(r, d);
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                exp_idx.push_back(k);
                exp_val.push_back(qmul(d, mw[k]));
                mw[k] = sat(longint'(mw[k]) + longint'(qmul(step, int'(iv[32*k +: 32]))));
            end
        end
        base_done = done_cnt;
        delta = d; rate = r; enabled = en; in_vec = iv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
            if (cyc == restart_at - 1) begin
                start = 1'b1;
                delta = 32'h00050000;
                rate  = 32'h00030000;
            end
            if (cyc == restart_at) start = 1'b0;
        end
        check_eq({tag, "_done_edge"}, cyc, N + 2);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_cnt"}, done_cnt - base_done, 32'd1);
        check_eq({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_q_empty"}, exp_idx.size(), 32'd0);
        check_weights(tag);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    logic [N*32-1:0] iv;
    int snap;

    initial begin
        reset = 1'b1; start = 1'b0; delta = '0; rate = '0; enabled = '0; in_vec = '0;
        w_rd_idx = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_busy",  {31'b0, busy}, 32'd0);
        check_eq("rst_done",  {31'b0, done}, 32'd0);
        check_eq("rst_bvld",  {31'b0, back_valid}, 32'd0);
        check_eq("rst_bidx",  {27'b0, back_idx}, 32'd0);
        check_eq("rst_bval",  back_val, 32'd0);
        check_eq("rst_w0",    w_rd_data, 32'h00010000);
        w_rd_idx = 5'd31;
        #1 check_eq("rst_w31", w_rd_data, 32'h00010000);
        reset = 1'b0;

        // Unit error, unit rate, lane 0 only.
        for (int k = 0; k < N; k++) iv[32*k +: 32] = $urandom;
        iv[31:0] = 32'h00010000;
        run_pass(32'h00010000, 32'h00010000, 32'h1, iv, 0, "t030");
        w_rd_idx = 5'd0; #1 check_eq("t030_w0_abs", w_rd_data, 32'h00020000);
        w_rd_idx = 5'd1; #1 check_eq("t030_w1_abs", w_rd_data, 32'h00010000);

        // Negative unit error.
        do_reset();
        run_pass(32'hFFFF0000, 32'h00010000, 32'h1, iv, 0, "t031");
        w_rd_idx = 5'd0; #1 check_eq("t031_w0_abs", w_rd_data, 32'h00000000);

        // Saturation across three passes.
        do_reset();
        iv[31:0] = 32'h7FFF0000;
        for (int p = 0; p < 3; p++) begin
            run_pass(32'h7FFF0000, 32'h7FFF0000, 32'h1, iv, 0, $sformatf("t032_%0d", p));
            w_rd_idx = 5'd0; #1 check_eq($sformatf("t032_%0d_w0_abs", p), w_rd_data, 32'h7FFFFFFF);
        end

        // Start re-pulsed mid-pass must be ignored.
        do_reset();
        for (int k = 0; k < N; k++) iv[32*k +: 32] = int'($urandom & 32'h0003FFFF) - 32'h00020000;
        run_pass(32'h00008000, 32'h00004000, {N{1'b1}}, iv, 5, "t033");

        // Odd lanes only, negative error.
        do_reset();
        for (int k = 0; k < N; k++) iv[32*k +: 32] = int'($urandom & 32'h000FFFFF) - 32'h00080000;
        run_pass(32'hFFFE8000, 32'h00010000, 32'hAAAAAAAA, iv, 0, "t035");
        w_rd_idx = 5'd2; #1 check_eq("t035_w2_abs", w_rd_data, 32'h00010000);

        // Reset in the middle of an all-lanes pass.
        ignore_back = 1'b1;
        snap = done_cnt;
        delta = 32'h00010000; rate = 32'h00010000; enabled = {N{1'b1}};
        for (int k = 0; k < N; k++) in_vec[32*k +: 32] = 32'h00010000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("t034_busy", {31'b0, busy}, 32'd0);
        check_eq("t034_bvld", {31'b0, back_valid}, 32'd0);
        model_reset();
        check_weights("t034");
        repeat (40) @(posedge clk);
        check_eq("t034_no_done", done_cnt, snap);
        #1 reset = 1'b0;
        ignore_back = 1'b0;

        // Start on the very first edge after reset release.
        for (int k = 0; k < N; k++) iv[32*k +: 32] = int'($urandom & 32'h0001FFFF) - 32'h00010000;
        run_pass(32'h00024000, 32'hFFFF8000, {N{1'b1}}, iv, 0, "t029");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
